// File: rtl/ddfs_pkg.sv
// Shared types and constants for the ddfs_gen frequency synthesiser.
// Holds the waveform-mode enum, dither LFSR constants and default widths.
package ddfs_pkg;

    localparam int DEF_PHASE_W = 24;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 12;

    typedef enum logic [1:0] {
        SINE     = 2'd0,
        TRIANGLE = 2'd1,
        SQUARE   = 2'd2,
        SAW      = 2'd3
    } wave_mode_e;

    // x^16 + x^14 + x^13 + x^11 + 1, taps on bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ddfs_gen_quarter_sin_lut.sv
// Quarter-wave sine ROM with a one-cycle registered read.
// Entries are computed at elaboration with a fixed-point Taylor series.
module quarter_sin_lut #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-2:0] data_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam longint PI_Q30 = 64'sd3373259426;

    // round((2^(DATA_W-1)-1) * sin((i+0.5)*pi/2^(ADDR_W+1))), angles in Q30
    function automatic logic [DATA_W-2:0] lut_val(input int i);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint full;
        x    = (longint'(2 * i + 1) * PI_Q30) >>> (ADDR_W + 2);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        full = longint'((1 << (DATA_W - 1)) - 1);
        return (DATA_W-1)'((sum * full + (64'sd1 <<< 29)) >>> 30);
    endfunction

    logic [DATA_W-2:0] rom [DEPTH];
    logic [DATA_W-2:0] data_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [DATA_W-2:0] VAL = lut_val(gi);
        assign rom[gi] = VAL;
    end

    always_ff @(posedge clk) begin
        data_q <= rom[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/ddfs_gen.sv
// Direct digital frequency synthesiser: phase accumulator, quarter-wave LUT,
// four waveforms and amplitude scaling. Define DDFS_DITHER_EN for LFSR phase dither.
module ddfs_gen
    import ddfs_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] fw_in,
    input  logic               fw_load,
    output logic               fw_busy,
    input  logic               sync_in,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic [DATA_W-1:0]  amp,
    output logic [DATA_W-1:0]  q,
    output logic               q_valid,
    output logic               wrap
);

    localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    // Accumulator and frequency-word update control
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] fw_act_q, fw_act_d;
    logic [PHASE_W-1:0] fw_pend_q, fw_pend_d;
    logic               pend_q, pend_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W:0]   sum_w;
    logic               step_w, carry_w, apply_w;

    assign sum_w   = {1'b0, acc_q} + {1'b0, fw_act_q};
    assign carry_w = sum_w[PHASE_W];
    assign step_w  = en & ~sync_in;
    // A pending word lands on the carry step or on sync, never mid-period
    assign apply_w = sync_in | (step_w & carry_w);

    always_comb begin
        acc_d     = acc_q;
        fw_act_d  = fw_act_q;
        fw_pend_d = fw_pend_q;
        pend_d    = pend_q;
        wrap_d    = step_w & carry_w;
        if (sync_in) begin
            acc_d = '0;
        end else if (step_w) begin
            acc_d = sum_w[PHASE_W-1:0];
        end
        if (fw_load) begin
            fw_pend_d = fw_in;
        end
        if (apply_w) begin
            if (fw_load) begin
                fw_act_d = fw_in;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                fw_act_d = fw_pend_q;
                pend_d   = 1'b0;
            end
        end else if (fw_load) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            fw_act_q  <= '0;
            fw_pend_q <= '0;
            pend_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            fw_act_q  <= fw_act_d;
            fw_pend_q <= fw_pend_d;
            pend_q    <= pend_d;
            wrap_q    <= wrap_d;
        end
    end

    // Phase formation
    logic [PHASE_W-1:0] p_w;

`ifdef DDFS_DITHER_EN
    localparam logic [PHASE_W-1:0] DITH_MASK =
        PHASE_W'((64'd1 << (PHASE_W - ADDR_W - 2)) - 64'd1);
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign p_w = acc_q + phase_off + (PHASE_W'(lfsr_q) & DITH_MASK);
`else
    assign p_w = acc_q + phase_off;
`endif

    logic [1:0]        quad_w;
    logic [ADDR_W-1:0] idx_w, fidx_w;

    assign quad_w = p_w[PHASE_W-1 -: 2];
    assign idx_w  = p_w[PHASE_W-3 -: ADDR_W];
    assign fidx_w = quad_w[0] ? ~idx_w : idx_w;

    // Stage 1 and stage 2 registers
    logic              v1_q, v2_q;
    logic [1:0]        quad_s1_q, quad_s2_q;
    logic [ADDR_W-1:0] fidx_s1_q, fidx_s2_q;
    wave_mode_e        mode_s1_q, mode_s2_q;
    logic [DATA_W-1:0] amp_s1_q, amp_s2_q;
    logic [DATA_W-1:0] saw_s1_q, saw_s2_q;
    logic [DATA_W-2:0] lut_data_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            quad_s1_q <= '0;
            quad_s2_q <= '0;
            fidx_s1_q <= '0;
            fidx_s2_q <= '0;
            mode_s1_q <= SINE;
            mode_s2_q <= SINE;
            amp_s1_q  <= '0;
            amp_s2_q  <= '0;
            saw_s1_q  <= '0;
            saw_s2_q  <= '0;
        end else begin
            v1_q      <= en;
            quad_s1_q <= quad_w;
            fidx_s1_q <= fidx_w;
            mode_s1_q <= wave_mode_e'(mode);
            amp_s1_q  <= amp;
            saw_s1_q  <= p_w[PHASE_W-1 -: DATA_W];
            v2_q      <= v1_q;
            quad_s2_q <= quad_s1_q;
            fidx_s2_q <= fidx_s1_q;
            mode_s2_q <= mode_s1_q;
            amp_s2_q  <= amp_s1_q;
            saw_s2_q  <= saw_s1_q;
        end
    end

    quarter_sin_lut #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lut (
        .clk    (clk),
        .addr_i (fidx_s1_q),
        .data_o (lut_data_w)
    );

    // Stage 3: sign, select, scale
    logic [DATA_W-1:0]          mag_w;
    logic signed [DATA_W-1:0]   s_w;
    logic [DATA_W:0]            amp_p1_w;
    logic signed [DATA_W+1:0]   amp_w;
    logic signed [2*DATA_W+1:0] prod_w;
    logic [DATA_W-1:0]          q_d;

    always_comb begin
        mag_w = '0;
        case (mode_s2_q)
            SINE:     mag_w = DATA_W'(lut_data_w);
            TRIANGLE: mag_w = DATA_W'(fidx_s2_q) << (DATA_W - 1 - ADDR_W);
            SQUARE:   mag_w = MAX_POS;
            default:  mag_w = '0;
        endcase
        if (mode_s2_q == SAW) begin
            s_w = {~saw_s2_q[DATA_W-1], saw_s2_q[DATA_W-2:0]};
        end else begin
            s_w = quad_s2_q[1] ? -mag_w : mag_w;
        end
    end

    assign amp_p1_w = {1'b0, amp_s2_q} + (DATA_W+1)'(1);
    assign amp_w    = signed'({1'b0, amp_p1_w});
    assign prod_w   = (2*DATA_W+2)'(s_w) * (2*DATA_W+2)'(amp_w);
    // Low DATA_W bits of (prod >>> DATA_W), re-centred to offset binary
    assign q_d      = prod_w[2*DATA_W-1:DATA_W] + MID;

    logic [DATA_W-1:0] q_q;
    logic              q_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= MID;
            q_valid_q <= 1'b0;
        end else begin
            q_valid_q <= v2_q;
            if (v2_q) begin
                q_q <= q_d;
            end
        end
    end

    logic unused_w;
    assign unused_w = ^{p_w, prod_w};

    // q_valid marks a fresh sample for one cycle; there is no back-pressure
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign wrap    = wrap_q;
    assign fw_busy = pend_q;

endmodule

// File: doc/ddfs_gen.md
# ddfs_gen

Parametrised second-generation direct digital frequency synthesiser for the function generator. It uses a wide phase accumulator with phase offset, a quarter-wave sine LUT, four waveform modes, amplitude scaling, phase-continuous frequency-word updates and an explicit phase-sync input. It sits between the control interface and the DAC driver and produces an offset-binary sample on every enabled clock.

## Interface
- PHASE_W, 24: phase accumulator width; must be ≥ ADDR_W+2.
- ADDR_W, 10: quarter-wave LUT address width.
- DATA_W, 12: output sample width; must be ≥ ADDR_W+1.
- Clock is `clk`; reset is `rst`, synchronous and active-high. One clock domain only.
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  advance accumulator and pipeline valid.
- fw_in  in  PHASE_W  frequency word (phase step per cycle).
- fw_load  in  1  one-cycle strobe that captures fw_in into the pending register.
- fw_busy  out  1  a pending word is waiting for wrap.
- sync_in  in  1  phase reset strobe.
- mode  in  2  waveform: 0 sine, 1 triangle, 2 square, 3 sawtooth.
- phase_off  in  PHASE_W  phase offset added after the accumulator.
- amp  in  DATA_W  amplitude; scale = (amp+1)/2^DATA_W.
- q  out  DATA_W  offset-binary sample.
- q_valid  out  1  q holds a new sample.
- wrap  out  1  one-cycle pulse on accumulator overflow.

## Operation
- Accumulator `acc`:
  - When en=1: acc <= acc + fw_act (mod 2^PHASE_W).
  - wrap=1 in the cycle after a carry out.
  - When en=0: acc holds.
- fw_load:
  - fw_pend <= fw_in and pend <= 1.
  - A load while pend=1 overwrites fw_pend.
  - On the step that carries out, fw_act <= fw_pend and pend <= 0. That step itself uses the old fw_act.
  - If fw_load and the carry step occur in the same cycle, fw_in goes directly to fw_act.
- sync_in has priority over en:
  - acc <= 0.
  - If pend=1, the pending word is applied and pend <= 0.
  - wrap stays 0.
- Phase `p` = acc + phase_off (mod 2^PHASE_W).
  - quad = p[PHASE_W-1:PHASE_W-2].
  - idx = next ADDR_W bits.
  - fidx = idx for quad 0/2; fidx = ~idx for quad 1/3.
- LUT: entry i = round((2^(DATA_W-1)-1)·sin((i+0.5)·π/2^(ADDR_W+1))), unsigned, DATA_W-1 bits, synchronous read.
- Signed sample s (DATA_W bits); negative for quad 2/3 in sine, triangle and square:
  - sine: ±LUT[fidx].
  - triangle: ±(fidx << (DATA_W-1-ADDR_W)).
  - square: ±(2^(DATA_W-1)-1).
  - sawtooth: p[PHASE_W-1 -: DATA_W] with MSB inverted.
- Scaling and output:
  - y = (s·(amp+1)) >>> DATA_W, full-width signed multiply with arithmetic shift.
  - q = y + 2^(DATA_W-1), truncated to DATA_W bits.
- mode, amp and phase_off are sampled in stage 1 together with the phase they apply to.
- Reset values:
  - acc=0, fw_act=0, fw_pend=0, pend=0.
  - q=2^(DATA_W-1) (midscale).
  - q_valid=0, wrap=0, fw_busy=0.
  - Pipeline valid bits cleared.
- Reset mid-operation discards all in-flight samples and any pending word.

## Timing
- Pipeline stages:
  - S1: registers quad, fidx, mode, amp, and sawtooth bits of p.
  - S2: LUT read.
  - S3: sign, select, multiply; q registered.
- Latency: the acc value present at cycle n produces q at cycle n+3.
- q_valid = en delayed 3 cycles. q holds its last value while q_valid=0.
- fw_busy = pend, registered, and asserts the cycle after fw_load.
- After sync_in at cycle n, the first phase-0 sample is on q at n+4.

## Configuration
- `DDFS_DITHER_EN` defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advances when en=1) is added to p in the bits below idx before truncation.
  - Only the low PHASE_W-ADDR_W-2 bits are added, zero-extended.
  - Spurs are spread; the output is non-deterministic with respect to the reference model.
- Undefined: no LFSR is present and p is truncated exactly.

## Structure
- Package `ddfs_pkg`:
  - wave-mode enum (SINE, TRIANGLE, SQUARE, SAW).
  - LFSR seed and taps constants.
  - Default width constants.
- Sub-module `quarter_sin_lut`: parameters ADDR_W and DATA_W, synchronous ROM, 1-cycle read, table generated at elaboration.
- Accumulator, update control, pipeline and scaling stay in `ddfs_gen`.

## Test plan
Defaults throughout, dither off, amp=12'hFFF unless stated.
- Reset: hold rst for 2 cycles → q=12'h800, q_valid=0, wrap=0, fw_busy=0.
- Square: fw=24'h040000, en=1 → wrap every 64 cycles; q=12'hFFF for 32 valid samples, then 12'h001 for 32.
- Sawtooth: fw=24'h001000 → q steps 12'h000, 12'h001, … by +1 per cycle, starting 3 cycles after en rises; wrap when q returns to 12'h000.
- Sine phase: phase_off=24'h400000, sync_in pulse → first sample q=12'hFFF; with phase_off=0, first sample q=12'h802.
- Frequency load: running at fw=24'h040000, fw_load with 24'h080000 at cycle 10 → fw_busy high until the carry step at cycle 63; the following period is 32 cycles and contains no discontinuity.
- Amplitude and reset: square mode, amp=12'h7FF → q alternates 12'hBFF/12'h400. Asserting rst mid-stream drives q=12'h800 and q_valid=0 on the next edge.
